// File: rtl/mult_sched.sv
// Round-robin scheduler that shares one mult_4 shift-add multiplier among N_REQ requesters.
// Optional watchdog on the multiplier is enabled by defining MULT_TIMEOUT_EN.
module mult_sched #(
    parameter int N_REQ   = 4,
    parameter int OPW     = 4,
    parameter int TMO_CYC = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*OPW-1:0] a_in,
    input  logic [N_REQ*OPW-1:0] b_in,
    output logic [N_REQ-1:0]     gnt,
    output logic [2*OPW-1:0]     res,
    output logic [N_REQ-1:0]     res_vld,
    output logic                 busy,
    output logic                 m_init,
    output logic [OPW-1:0]       m_a,
    output logic [OPW-1:0]       m_b,
    input  logic [2*OPW-1:0]     m_pp,
    input  logic                 m_done
`ifdef MULT_TIMEOUT_EN
    ,
    output logic                 err
`endif
);

    localparam int IDXW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("mult_sched: N_REQ must be 2..8");
    end
    if (TMO_CYC < 1 || TMO_CYC > 32) begin : g_bad_tmo
        $error("mult_sched: TMO_CYC must fit the 5-bit watchdog");
    end

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_START, S_WAIT, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [IDXW-1:0]   rr_ptr, idx, pick;
    logic              found;
    logic              first_wait;
    logic              done_ok;
    logic              finish;

    // First set request at or after rr_ptr, wrapping; the last winner ends up lowest priority.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[(int'(rr_ptr) + i) % N_REQ]) begin
                found = 1'b1;
                pick  = IDXW'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    // A done still high from the previous operation is ignored in the first WAIT cycle.
    assign done_ok = m_done && !first_wait;

`ifdef MULT_TIMEOUT_EN
    logic [4:0] wdog;
    logic       tmo_hit;
    logic       tmo_r;

    assign tmo_hit = !done_ok && (wdog == 5'(TMO_CYC - 1));
    assign finish  = done_ok || tmo_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog  <= '0;
            tmo_r <= 1'b0;
        end else if (state == S_START) begin
            wdog  <= '0;
            tmo_r <= 1'b0;
        end else if (state == S_WAIT) begin
            wdog  <= wdog + 5'd1;
            tmo_r <= tmo_hit;
        end
    end
`else
    assign finish = done_ok;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every next-state path starts from a default so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|req) state_nxt = S_ARB;
            S_ARB:   state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (finish) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= '0;
            idx        <= '0;
            gnt        <= '0;
            res        <= '0;
            m_a        <= '0;
            m_b        <= '0;
            first_wait <= 1'b0;
        end else begin
            case (state)
                S_ARB: begin
                    idx <= pick;
                    gnt <= N_REQ'(1) << pick;
                    m_a <= a_in[int'(pick)*OPW +: OPW];
                    m_b <= b_in[int'(pick)*OPW +: OPW];
                end
                S_START: first_wait <= 1'b1;
                S_WAIT: begin
                    first_wait <= 1'b0;
                    if (done_ok) begin
                        res <= m_pp;
                    end
`ifdef MULT_TIMEOUT_EN
                    else if (tmo_hit) begin
                        res <= '0;
                    end
`endif
                end
                S_DONE: begin
                    gnt    <= '0;
                    rr_ptr <= (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // gnt is one-hot on idx, so masking it with req suppresses the pulse of a dropped requester.
    always_comb begin
        busy    = (state != S_IDLE);
        m_init  = (state == S_START);
        res_vld = (state == S_DONE) ? (gnt & req) : '0;
`ifdef MULT_TIMEOUT_EN
        err     = (state == S_DONE) && tmo_r;
`endif
    end

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched with a behavioural mult_4 model and a result scoreboard.
module tb_mult_sched;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int LAT = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] a_in = '0;
    logic [N*W-1:0] b_in = '0;
    logic [N-1:0]   gnt;
    logic [2*W-1:0] res;
    logic [N-1:0]   res_vld;
    logic           busy;
    logic           m_init;
    logic [W-1:0]   m_a, m_b;
    logic [2*W-1:0] m_pp;
    logic           m_done;
`ifdef MULT_TIMEOUT_EN
    logic           err;
`endif

    mult_sched #(.N_REQ(N), .OPW(W), .TMO_CYC(31)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .res(res), .res_vld(res_vld), .busy(busy),
        .m_init(m_init), .m_a(m_a), .m_b(m_b), .m_pp(m_pp), .m_done(m_done)
`ifdef MULT_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // mult_4 model: done stays high after finishing and only drops one cycle after the next init.
    logic [W-1:0]   ma_r, mb_r;
    logic [2:0]     cnt_r;
    logic           done_r;
    logic           kill = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma_r <= '0; mb_r <= '0; cnt_r <= '0; done_r <= 1'b0; m_pp <= '0;
        end else if (m_init) begin
            ma_r <= m_a; mb_r <= m_b; cnt_r <= 3'(LAT);
        end else if (cnt_r != 0) begin
            cnt_r <= cnt_r - 3'd1;
            if (cnt_r == 3'(LAT)) done_r <= 1'b0;
            if (cnt_r == 3'd1) begin
                done_r <= 1'b1;
                m_pp   <= {4'b0, ma_r} * {4'b0, mb_r};
            end
        end
    end
    assign m_done = done_r & ~kill;

    typedef struct {int idx; int prod; bit err;} exp_t;
    exp_t sb[$];
    exp_t e;
    int total = 0, bad = 0, init_cycles = 0, vld_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input int prod, input bit er);
        exp_t x;
        x.idx = idx; x.prod = prod; x.err = er;
        sb.push_back(x);
    endtask

    function automatic logic [N*W-1:0] pack(input int v0, input int v1, input int v2, input int v3);
        return {W'(v3), W'(v2), W'(v1), W'(v0)};
    endfunction

    // Monitor: pop one expectation per result pulse.
    always @(negedge clk) begin
        if (rst) begin
            if (m_init) init_cycles++;
            if (res_vld != 0) begin
                vld_seen++;
                if (sb.size() == 0) begin
                    check("unexpected_vld", 32'(res_vld), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("vld_owner", 32'(res_vld), 32'(1) << e.idx);
                    check("res", 32'(res), e.prod);
                    check("gnt_at_vld", 32'(gnt), 32'(res_vld));
`ifdef MULT_TIMEOUT_EN
                    check("err_at_vld", 32'(err), 32'(e.err));
`endif
                end
            end
`ifdef MULT_TIMEOUT_EN
            else if (err) check("err_without_vld", 32'(err), 32'd0);
`endif
        end
    end

    task automatic wait_vld(input int n);
        int start = vld_seen;
        int cyc = 0;
        while (vld_seen - start < n && cyc < 300) begin
            @(negedge clk); #1; cyc++;
        end
        check("vld_count", 32'(vld_seen - start), 32'(n));
        @(posedge clk); #1;
        req = '0;
    endtask

    task automatic wait_init();
        int cyc = 0;
        do begin
            @(negedge clk); #1; cyc++;
        end while (!m_init && cyc < 50);
        check("m_init_seen", 32'(m_init), 32'd1);
    endtask

    task automatic wait_gnt();
        int cyc = 0;
        do begin
            @(negedge clk); #1; cyc++;
        end while (gnt == 0 && cyc < 50);
    endtask

    initial begin
        int i0, n;
        // Reset with every requester asking
        req  = 4'hF;
        a_in = pack(3, 6, 11, 9);
        b_in = pack(5, 7, 2, 13);
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_vld", 32'(res_vld), 0);
        check("rst_init", 32'(m_init), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_res", 32'(res), 0);
        check("rst_ma", 32'(m_a), 0);
        // Round robin 0,1,2,3,0 with req held
        push(0, 15, 0); push(1, 42, 0); push(2, 22, 0); push(3, 117, 0); push(0, 15, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        wait_gnt();
        check("first_gnt", 32'(gnt), 32'b0001);
        wait_vld(5);

        // Single op on requester 2; operands changed after ARB must not matter
        a_in = pack(0, 0, 7, 0);
        b_in = pack(0, 0, 9, 0);
        req  = 4'b0100;
        push(2, 63, 0);
        i0 = init_cycles;
        wait_init();
        check("m_a", 32'(m_a), 7);
        check("m_b", 32'(m_b), 9);
        a_in = pack(1, 1, 1, 1);
        b_in = pack(2, 2, 2, 2);
        wait_vld(1);
        check("init_pulses", 32'(init_cycles - i0), 1);

        // Edge values back to back: rr_ptr is 3, so 3 goes first
        a_in = pack(0, 0, 0, 15);
        b_in = pack(13, 0, 0, 15);
        req  = 4'b1001;
        push(3, 225, 0); push(0, 0, 0);
        wait_vld(2);

        // Abort: requester 1 drops during WAIT, next grant is 2
        a_in = pack(0, 5, 12, 0);
        b_in = pack(0, 5, 10, 0);
        req  = 4'b0110;
        push(2, 120, 0);
        wait_init();
        check("abort_gnt1", 32'(gnt), 32'b0010);
        @(negedge clk); #1;
        req = 4'b0100;
        n = 0;
        while (busy && n < 50) begin @(negedge clk); #1; n++; end
        check("abort_idle", 32'(busy), 0);
        wait_gnt();
        check("abort_next_gnt", 32'(gnt), 32'b0100);
        wait_vld(1);

        // Reset while in WAIT
        a_in = pack(0, 0, 0, 8);
        b_in = pack(0, 0, 0, 6);
        req  = 4'b1000;
        wait_init();
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(gnt), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_vld", 32'(res_vld), 0);
        check("mid_rst_init", 32'(m_init), 0);
        check("mid_rst_ma", 32'(m_a), 0);
        check("mid_rst_mb", 32'(m_b), 0);
        req = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        req = 4'b1000;
        push(3, 48, 0);
        wait_vld(1);

`ifdef MULT_TIMEOUT_EN
        // Multiplier never answers: watchdog ends the operation with res=0 and err
        kill = 1'b1;
        a_in = pack(0, 3, 0, 0);
        b_in = pack(0, 3, 0, 0);
        req  = 4'b0010;
        push(1, 0, 1);
        wait_init();
        n = 0;
        do begin @(negedge clk); #1; n++; end while (res_vld == 0 && n < 100);
        check("tmo_cycles", 32'(n), 32);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk); #1;
        check("tmo_idle", 32'(busy), 0);
        kill = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
